// File: rtl/muldiv_issue_ctrl.sv
// RV32M EX-stage front end for an iterative unsigned mul/div unit: operand magnitudes, issue, sign/special fixups.
// Latency: accept T -> ex_done T+35 (special cases T+1); pipeline stalls via ex_stall, flushed ops drain the busy unit.
module muldiv_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_req,
  input  logic        ex_flush,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  output logic        ex_stall,
  output logic        ex_done,
  output logic [31:0] ex_result,
  output logic        md_err,
  output logic        md_valid,
  output logic        md_mode,
  output logic [31:0] md_in_A,
  output logic [31:0] md_in_B,
  input  logic        md_ready,
  input  logic [63:0] md_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_FIX   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state;
  logic [2:0]    f3_q;
  logic          a_neg_q;
  logic          b_neg_q;
  logic [CW-1:0] cnt;
  logic [31:0]   res_q;
  logic [31:0]   last_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic          mode_q;
  logic          err_q;

  // Operand decode on the live EX inputs, used only on the accept cycle
  logic        a_sgn;
  logic        b_sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        div_zero;
  logic        div_ovf;

  always_comb begin
    a_sgn    = (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
               (ex_funct3 == 3'b100) || (ex_funct3 == 3'b110);
    b_sgn    = (ex_funct3 == 3'b001) || (ex_funct3 == 3'b100) ||
               (ex_funct3 == 3'b110);
    a_neg    = a_sgn && ex_rs1[31];
    b_neg    = b_sgn && ex_rs2[31];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    mag_a    = a_neg ? (32'd0 - ex_rs1) : ex_rs1;
    mag_b    = b_neg ? (32'd0 - ex_rs2) : ex_rs2;
    div_zero = ex_funct3[2] && (ex_rs2 == 32'd0);
    div_ovf  = ex_funct3[2] && !ex_funct3[0] &&
               (ex_rs1 == 32'h8000_0000) && (ex_rs2 == 32'hFFFF_FFFF);
  end

  // Sign fixup of the unit result for the latched op
  logic [63:0] prod_neg;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] fix_res;

  always_comb begin
    prod_neg = 64'd0 - md_out;
    quo      = md_out[31:0];
    rem      = md_out[63:32];
    fix_res  = 32'd0;
    case (f3_q)
      3'b000:  fix_res = md_out[31:0];
      3'b001:  fix_res = (a_neg_q ^ b_neg_q) ? prod_neg[63:32] : md_out[63:32];
      3'b010:  fix_res = a_neg_q ? prod_neg[63:32] : md_out[63:32];
      3'b011:  fix_res = md_out[63:32];
      3'b100:  fix_res = (a_neg_q ^ b_neg_q) ? (32'd0 - quo) : quo;
      3'b101:  fix_res = quo;
      3'b110:  fix_res = a_neg_q ? (32'd0 - rem) : rem;
      default: fix_res = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      f3_q    <= 3'd0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      cnt     <= '0;
      res_q   <= 32'd0;
      last_q  <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ex_req && !ex_flush) begin
            f3_q    <= ex_funct3;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            a_q     <= mag_a;
            b_q     <= mag_b;
            mode_q  <= ex_funct3[2];
            cnt     <= '0;
            if (div_zero) begin
              res_q <= ex_funct3[1] ? ex_rs1 : 32'hFFFF_FFFF;
              state <= S_FIX;
            end else if (div_ovf) begin
              res_q <= ex_funct3[1] ? 32'd0 : 32'h8000_0000;
              state <= S_FIX;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state <= ex_flush ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (md_ready) begin
            // a flush that coincides with the result needs no drain: the unit is already free
            res_q <= fix_res;
            state <= ex_flush ? S_IDLE : S_FIX;
          end else if (cnt == CNT_LAST) begin
            err_q <= 1'b1;
            res_q <= 32'd0;
            state <= ex_flush ? S_IDLE : S_FIX;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ex_flush ? S_DRAIN : S_WAIT;
          end
        end
        S_DRAIN: begin
          if (md_ready) begin
            state <= S_IDLE;
          end else if (cnt == CNT_LAST) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (!ex_flush) begin
            last_q <= res_q;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ex_done   = (state == S_FIX) && !ex_flush;
    ex_result = ex_done ? res_q : last_q;
    ex_stall  = ex_req && !ex_done;
    md_valid  = (state == S_ISSUE) && !ex_flush;
    md_mode   = mode_q;
    md_in_A   = a_q;
    md_in_B   = b_q;
    md_err    = err_q;
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl: behavioural RV32M reference, bus-level mul/div unit model, per-cycle output compare.
module tb_muldiv_issue_ctrl;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_req = 1'b0;
  logic        ex_flush = 1'b0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [31:0] ex_rs1 = 32'd0;
  logic [31:0] ex_rs2 = 32'd0;
  logic        ex_stall;
  logic        ex_done;
  logic [31:0] ex_result;
  logic        md_err;
  logic        md_valid;
  logic        md_mode;
  logic [31:0] md_in_A;
  logic [31:0] md_in_B;
  logic        md_ready = 1'b0;
  logic [63:0] md_out = 64'd0;

  muldiv_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_req(ex_req), .ex_flush(ex_flush),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_stall(ex_stall), .ex_done(ex_done), .ex_result(ex_result),
    .md_err(md_err), .md_valid(md_valid), .md_mode(md_mode),
    .md_in_A(md_in_A), .md_in_B(md_in_B), .md_ready(md_ready), .md_out(md_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Expectations of the in-flight op, in absolute cycle numbers
  int          exp_done_cyc = -1;
  int          exp_mvld_cyc = -1;
  int          err_cyc = -1;
  logic [31:0] exp_res = 32'd0;
  logic [31:0] last_res = 32'd0;
  logic [31:0] exp_a = 32'd0;
  logic [31:0] exp_b = 32'd0;
  logic        exp_mode = 1'b0;
  logic        chk_en = 1'b0;
  logic        unit_en = 1'b1;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [31:0] r;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    r   = 32'd0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mag(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  // Mul/div unit: result strobe 33 cycles after the issue pulse
  int          ready_cyc = -1;
  logic [63:0] unit_res = 64'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ready_cyc = -1;
    end else if (md_valid && unit_en) begin
      cmp("unit_idle_at_issue", 32'(ready_cyc >= cyc), 32'd0);
      ready_cyc = cyc + 33;
      if (md_mode)
        unit_res = (md_in_B == 0) ? 64'd0 : {md_in_A % md_in_B, md_in_A / md_in_B};
      else
        unit_res = {32'd0, md_in_A} * {32'd0, md_in_B};
    end
  end
  always @(posedge clk) begin
    #1;
    md_ready = rst_n && (cyc == ready_cyc);
    md_out   = md_ready ? unit_res : 64'd0;
  end

  // Per-cycle compare of all outputs against the expectations
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("ex_done", 32'(ex_done), 32'(cyc == exp_done_cyc));
      if (cyc == exp_done_cyc) begin
        cmp("ex_result", ex_result, exp_res);
        last_res = exp_res;
      end else begin
        cmp("ex_result_hold", ex_result, last_res);
      end
      cmp("ex_stall", 32'(ex_stall), 32'(ex_req && (cyc != exp_done_cyc)));
      cmp("md_valid", 32'(md_valid), 32'(cyc == exp_mvld_cyc));
      if (cyc == exp_mvld_cyc) begin
        cmp("md_in_A", md_in_A, exp_a);
        cmp("md_in_B", md_in_B, exp_b);
        cmp("md_mode", 32'(md_mode), 32'(exp_mode));
      end
      cmp("md_err", 32'(md_err), 32'(err_cyc >= 0 && cyc >= err_cyc));
    end
  end

  // Drive an op now; acc is the cycle in which the DUT is expected to take it
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int acc);
    logic special;
    special   = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    ex_req    = 1'b1;
    ex_funct3 = f;
    ex_rs1    = a;
    ex_rs2    = b;
    exp_a     = mag(f inside {3'd1, 3'd2, 3'd4, 3'd6}, a);
    exp_b     = mag(f inside {3'd1, 3'd4, 3'd6}, b);
    exp_mode  = f[2];
    if (special) begin
      exp_res      = ref_res(f, a, b);
      exp_mvld_cyc = -1;
      exp_done_cyc = acc + 1;
    end else if (!unit_en) begin
      exp_res      = 32'd0;
      exp_mvld_cyc = acc + 1;
      exp_done_cyc = acc + 2 + TO;
      err_cyc      = acc + 2 + TO;
    end else begin
      exp_res      = ref_res(f, a, b);
      exp_mvld_cyc = acc + 1;
      exp_done_cyc = acc + 35;
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (ex_done) seen = 1;
    end
    if (!seen) cmp("ex_done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    ex_req   = 1'b0;
    ex_flush = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start_op(f, a, b, cyc);
    wait_done();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'($urandom_range(0, 20));
      4: v = 32'd0 - 32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    // Reference model pinned against hand-computed results
    cmp("pin_mulhu", ref_res(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    cmp("pin_mulh", ref_res(3'd1, 32'hFFFF_FFFD, 32'd5), 32'hFFFF_FFFF);
    cmp("pin_mul", ref_res(3'd0, 32'hFFFF_FFFD, 32'd5), 32'hFFFF_FFF1);
    cmp("pin_div", ref_res(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    cmp("pin_rem", ref_res(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    cmp("pin_divu", ref_res(3'd5, 32'd100, 32'd7), 32'd14);
    cmp("pin_remu", ref_res(3'd7, 32'd100, 32'd7), 32'd2);
    cmp("pin_divu0", ref_res(3'd5, 32'h1234, 32'd0), 32'hFFFF_FFFF);
    cmp("pin_remu0", ref_res(3'd7, 32'h1234, 32'd0), 32'h1234);
    cmp("pin_div_ovf", ref_res(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    cmp("pin_rem_ovf", ref_res(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
    cmp("pin_mag_mulh", mag(1'b1, 32'hFFFF_FFFD), 32'd3);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("rst_ex_done", 32'(ex_done), 32'd0);
    cmp("rst_ex_result", ex_result, 32'd0);
    cmp("rst_ex_stall", 32'(ex_stall), 32'd0);
    cmp("rst_md_err", 32'(md_err), 32'd0);
    cmp("rst_md_valid", 32'(md_valid), 32'd0);
    cmp("rst_md_mode", 32'(md_mode), 32'd0);
    cmp("rst_md_in_A", md_in_A, 32'd0);
    cmp("rst_md_in_B", md_in_B, 32'd0);
    next_cycle();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    next_cycle();

    // Directed ops, back to back
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);
    run_op(3'd5, 32'h1234, 32'd0);
    run_op(3'd7, 32'h1234, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush in the issue cycle: no issue pulse, no completion
    start_op(3'd5, 32'd100, 32'd7, cyc);
    next_cycle();
    ex_flush     = 1'b1;
    exp_mvld_cyc = -1;
    exp_done_cyc = -1;
    next_cycle();
    ex_flush = 1'b0;
    ex_req   = 1'b0;
    run_op(3'd1, 32'h7FFF_FFFF, 32'h8000_0000);

    // Flush ten cycles into the wait: next op stalls until the unit drains
    begin
      int t;
      t = cyc;
      start_op(3'd4, 32'd1000, 32'hFFFF_FFF6, t);
      repeat (10) next_cycle();
      ex_flush     = 1'b1;
      exp_done_cyc = -1;
      next_cycle();
      ex_flush = 1'b0;
      start_op(3'd7, 32'hDEAD_BEEF, 32'd1000, t + 35);
      wait_done();
    end

    // Flush in the fixup cycle: completion suppressed, result register held
    start_op(3'd5, 32'h55, 32'd0, cyc);
    next_cycle();
    ex_flush     = 1'b1;
    exp_done_cyc = -1;
    next_cycle();
    ex_flush = 1'b0;
    ex_req   = 1'b0;
    next_cycle();

    // Random ops with random idle gaps
    for (int n = 0; n < 150; n++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
      repeat ($urandom_range(0, 2)) next_cycle();
    end

    // Reset in the middle of an op
    start_op(3'd0, 32'd12345, 32'd678, cyc);
    repeat (5) next_cycle();
    rst_n        = 1'b0;
    chk_en       = 1'b0;
    ex_req       = 1'b0;
    exp_done_cyc = -1;
    exp_mvld_cyc = -1;
    repeat (2) next_cycle();
    rst_n    = 1'b1;
    last_res = 32'd0;
    chk_en   = 1'b1;
    run_op(3'd6, 32'hFFFF_FF00, 32'd7);

    // Unit never answers: timeout, zero result, sticky error
    unit_en = 1'b0;
    run_op(3'd5, 32'd500, 32'd3);
    repeat (3) next_cycle();
    rst_n  = 1'b0;
    chk_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmp("reset_clears_md_err", 32'(md_err), 32'd0);
    cmp("reset_clears_result", ex_result, 32'd0);
    next_cycle();
    rst_n    = 1'b1;
    unit_en  = 1'b1;
    err_cyc  = -1;
    last_res = 32'd0;
    chk_en   = 1'b1;
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    repeat (3) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
